// File: rtl/phy_framer_if.sv
// Byte-stream, frame-memory write port and loader handshake of the PHY framer.
// master: the framer itself; slave: the byte source, memory and loader side.
interface phy_framer_if #(
  parameter int ADDR_W = 7
);
  // Byte stream
  logic              i_valid;
  logic [7:0]        i_byte;
  logic              i_last;
  logic              o_ready;
  // Frame memory write port
  logic              csb0;
  logic              web0;
  logic [ADDR_W-1:0] addr0;
  logic [11:0]       o_data;
  // Loader handshake and status pulses
  logic              ten;
  logic              tend;
  logic              o_done;
  logic              o_ovf;

  modport master (
    input  i_valid, i_byte, i_last, tend,
    output o_ready, csb0, web0, addr0, o_data, ten, o_done, o_ovf
  );

  modport slave (
    output i_valid, i_byte, i_last, tend,
    input  o_ready, csb0, web0, addr0, o_data, ten, o_done, o_ovf
  );
endinterface

// File: rtl/phy_framer.sv
// PHY framer: packs payload bytes into 12-bit UART-style frames, writes a full
// DEPTH-word image (optional SYNCH word, payload, idle pad) into frame memory,
// then hands the image to the loader through the ten/tend handshake.
module phy_framer #(
  parameter int DEPTH   = 128,
  parameter int SYNC_EN = 1,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  phy_framer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_PAD,
    S_START_TX,
    S_WAIT_TX
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);
  localparam logic [11:0]       PAD_WORD  = 12'hFFF;
  localparam logic [7:0]        SYNC_BYTE = 8'h55;

  // Start bit 0, data LSB-first in bits 8:1, even parity in bit 9, two stop bits.
  function automatic logic [11:0] frame(input logic [7:0] b);
    return {2'b11, ^b, b, 1'b0};
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              csb0_q, csb0_d;
  logic              web0_q, web0_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d;
  logic [11:0]       data_q, data_d;
  logic              ten_q, ten_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              wr;
  logic              tx_now, tx_next;

  // Next-state, word pointer and registered memory/loader outputs.
  always_comb begin
    // NOTE: every value written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ovf_d   = 1'b0;
    wr      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ptr_d = '0;
        if (bus.i_valid) begin
          if (SYNC_EN != 0) begin
            // The SYNCH word is written on the edge leaving IDLE, so it is on the bus during SYNC.
            state_d = S_SYNC;
            wr      = 1'b1;
            data_d  = frame(SYNC_BYTE);
            ptr_d   = ONE_ADDR;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_SYNC: state_d = S_DATA;

      S_DATA: begin
        if (bus.i_valid) begin
          wr     = 1'b1;
          data_d = frame(bus.i_byte);
          if (ptr_q == LAST_ADDR) begin
            // Memory is full: a non-final byte here means the packet is truncated.
            state_d = S_START_TX;
            ovf_d   = !bus.i_last;
          end else begin
            ptr_d = ptr_q + ONE_ADDR;
            if (bus.i_last) state_d = S_PAD;
          end
        end
      end

      S_PAD: begin
        wr     = 1'b1;
        data_d = PAD_WORD;
        if (ptr_q == LAST_ADDR) state_d = S_START_TX;
        else                    ptr_d   = ptr_q + ONE_ADDR;
      end

      // ten is still high on the first START_TX cycle, so a stale tend cannot advance us.
      S_START_TX: if (bus.tend && !ten_q) state_d = S_WAIT_TX;

      S_WAIT_TX: begin
        if (!bus.tend) begin
          state_d = S_IDLE;
          ptr_d   = '0;
          done_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    csb0_d  = !wr;
    web0_d  = !wr;
    // While writing, show the written address; otherwise pre-present the next pointer.
    addr0_d = wr ? ptr_q : ptr_d;

    // ten falls one cycle after entering START_TX, so the final strobe is complete first.
    tx_now  = (state_q == S_START_TX) || (state_q == S_WAIT_TX);
    tx_next = (state_d == S_START_TX) || (state_d == S_WAIT_TX);
    ten_d   = !(tx_now && tx_next);
  end

  // State and output registers; reset abandons any packet and releases ten at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      csb0_q  <= 1'b1;
      web0_q  <= 1'b1;
      addr0_q <= '0;
      data_q  <= PAD_WORD;
      ten_q   <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      csb0_q  <= csb0_d;
      web0_q  <= web0_d;
      addr0_q <= addr0_d;
      data_q  <= data_d;
      ten_q   <= ten_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.o_ready = (state_q == S_DATA);
  assign bus.csb0    = csb0_q;
  assign bus.web0    = web0_q;
  assign bus.addr0   = addr0_q;
  assign bus.o_data  = data_q;
  assign bus.ten     = ten_q;
  assign bus.o_done  = done_q;
  assign bus.o_ovf   = ovf_q;

endmodule

// File: tb/tb_phy_framer.sv
// Self-checking bench for phy_framer: instance 0 has SYNC_EN=1, instance 1 has
// SYNC_EN=0. Expected memory images are queued by the stimulus side and popped
// by a monitor on every observed write strobe.
module tb_phy_framer;

  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    int          inst;
    int          addr;
    logic [11:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  int         sel;
  logic       valid;
  logic [7:0] in_byte;
  logic       in_last;

  logic              ready_w [2];
  logic              csb_w   [2];
  logic              web_w   [2];
  logic              ten_w   [2];
  logic              done_w  [2];
  logic              ovf_w   [2];
  logic [ADDR_W-1:0] addr_w  [2];
  logic [11:0]       data_w  [2];

  wr_t  exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ovf_cnt      [2];
  int   done_cnt     [2];
  int   ten_fall_cnt [2];
  logic prev_ten     [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    phy_framer_if #(.ADDR_W(ADDR_W)) bus ();
    logic tend_l;

    assign bus.i_valid = valid && (sel == g);
    assign bus.i_byte  = in_byte;
    assign bus.i_last  = in_last;
    assign bus.tend    = tend_l;
    assign ready_w[g]  = bus.o_ready;
    assign csb_w[g]    = bus.csb0;
    assign web_w[g]    = bus.web0;
    assign ten_w[g]    = bus.ten;
    assign done_w[g]   = bus.o_done;
    assign ovf_w[g]    = bus.o_ovf;
    assign addr_w[g]   = bus.addr0;
    assign data_w[g]   = bus.o_data;

    phy_framer #(
      .DEPTH  (DEPTH),
      .SYNC_EN((g == 0) ? 1 : 0),
      .ADDR_W (ADDR_W)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.master)
    );

    // Loader model: busy 3 cycles after ten falls, for 50 cycles.
    initial tend_l = 1'b0;
    always begin
      @(negedge bus.ten);
      repeat (3) @(posedge clk);
      #1 tend_l = 1'b1;
      repeat (50) @(posedge clk);
      #1 tend_l = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference frame: stop bits 0xC00, parity by counting ones, data shifted up one bit.
  function automatic logic [11:0] frame_of(input logic [7:0] b);
    int ones = 0;
    for (int k = 0; k < 8; k++) ones += int'(b[k]);
    return 12'(3072 + (ones % 2) * 512 + int'(b) * 2);
  endfunction

  // Queue the complete DEPTH-word image the packet must produce.
  task automatic push_image(input int inst, input byte_q_t pkt, input int n_acc);
    int off = (inst == 0) ? 1 : 0;
    for (int a = 0; a < DEPTH; a++) begin
      wr_t e;
      e.inst = inst;
      e.addr = a;
      if (off == 1 && a == 0)  e.data = frame_of(8'h55);
      else if (a - off < n_acc) e.data = frame_of(pkt[a - off]);
      else                      e.data = 12'hFFF;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_bytes(input int inst, input byte_q_t pkt, input int n,
                             input bit has_last, input int max_gap);
    sel = inst;
    for (int i = 0; i < n; i++) begin
      bit got = 1'b0;
      if (max_gap > 0 && i > 0) begin
        valid = 1'b0;
        repeat ($urandom_range(1, max_gap)) @(posedge clk);
        #1;
      end
      valid   = 1'b1;
      in_byte = pkt[i];
      in_last = has_last && (i == pkt.size() - 1);
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        if (ready_w[inst]) begin
          @(posedge clk);
          #1;
          got = 1'b1;
        end
      end
      check("byte_accepted", got, 1);
      if (!got) break;
    end
    valid   = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_packet(input int inst, input byte_q_t pkt, input bit has_last,
                             input int max_gap);
    int room = DEPTH - ((inst == 0) ? 1 : 0);
    int n_acc;
    bit exp_ovf;
    int ovf0, done0, fall0;
    bit seen = 1'b0;
    exp_ovf = (pkt.size() > room) || (pkt.size() == room && !has_last);
    n_acc   = (pkt.size() < room) ? pkt.size() : room;
    ovf0  = ovf_cnt[inst];
    done0 = done_cnt[inst];
    fall0 = ten_fall_cnt[inst];
    push_image(inst, pkt, n_acc);
    drive_bytes(inst, pkt, n_acc, has_last, max_gap);
    if (exp_ovf) begin
      valid   = 1'b1;
      in_byte = 8'($urandom);
      in_last = 1'b0;
      repeat (4) begin
        @(negedge clk);
        check("ready_low_after_ovf", ready_w[inst], 0);
      end
      valid = 1'b0;
    end
    for (int t = 0; t < 1000 && !seen; t++) begin
      @(negedge clk);
      if (done_w[inst]) begin
        seen = 1'b1;
        check("ten_high_with_done", ten_w[inst], 1);
      end
    end
    check("done_seen", seen, 1);
    @(negedge clk);
    #1;
    check("done_single_cycle", done_w[inst], 0);
    check("idle_ready_low", ready_w[inst], 0);
    check("idle_ten_high", ten_w[inst], 1);
    check("done_count", done_cnt[inst] - done0, 1);
    check("ovf_count", ovf_cnt[inst] - ovf0, exp_ovf);
    check("ten_fall_count", ten_fall_cnt[inst] - fall0, 1);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic reset_during_pad();
    byte_q_t p;
    bit found = 1'b0;
    int fall0;
    p.push_back(8'h3C);
    p.push_back(8'h81);
    p.push_back(8'h7E);
    fall0 = ten_fall_cnt[1];
    push_image(1, p, 3);
    drive_bytes(1, p, 3, 1'b1, 0);
    for (int t = 0; t < 300 && !found; t++) begin
      @(negedge clk);
      if (!csb_w[1] && addr_w[1] == ADDR_W'(60)) found = 1'b1;
    end
    check("pad_reached_addr60", found, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_csb0_immediate", csb_w[1], 1);
    check("rst_web0_immediate", web_w[1], 1);
    check("rst_ten_high", ten_w[1], 1);
    check("rst_addr0_zero", addr_w[1], 0);
    check("rst_data_idle", data_w[1], 12'hFFF);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_no_write", csb_w[1], 1);
    check("post_rst_ten_high", ten_w[1], 1);
    check("post_rst_no_ten_fall", ten_fall_cnt[1] - fall0, 0);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (rst) begin
          prev_ten[g] = 1'b1;
          continue;
        end
        if (prev_ten[g] && !ten_w[g]) begin
          ten_fall_cnt[g]++;
          check("image_complete_before_ten", exp_q.size(), 0);
        end
        prev_ten[g] = ten_w[g];
        check("web0_tracks_csb0", web_w[g], csb_w[g]);
        if (!csb_w[g]) begin
          check("write_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            wr_t e = exp_q.pop_front();
            check("write_inst", g, e.inst);
            check("write_addr", addr_w[g], e.addr);
            check("write_data", data_w[g], e.data);
          end
        end
        if (done_w[g]) done_cnt[g]++;
        if (ovf_w[g])  ovf_cnt[g]++;
      end
    end
  endtask

  initial begin
    byte_q_t p;
    rst     = 1'b0;
    valid   = 1'b0;
    in_byte = 8'h00;
    in_last = 1'b0;
    sel     = 0;
    #1 rst = 1'b1;
    #3;
    for (int g = 0; g < 2; g++) begin
      check("reset_csb0", csb_w[g], 1);
      check("reset_web0", web_w[g], 1);
      check("reset_addr0", addr_w[g], 0);
      check("reset_o_data", data_w[g], 12'hFFF);
      check("reset_ten", ten_w[g], 1);
      check("reset_o_ready", ready_w[g], 0);
      check("reset_o_done", done_w[g], 0);
      check("reset_o_ovf", ovf_w[g], 0);
      prev_ten[g] = 1'b1;
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    fork
      monitor();
    join_none

    // SYNCH word, one byte 0x01, pad 2..127.
    p = {};
    p.push_back(8'h01);
    send_packet(0, p, 1'b1, 0);

    // No SYNCH: 0xA5, 0x00 then pad from 2.
    p = {};
    p.push_back(8'hA5);
    p.push_back(8'h00);
    send_packet(1, p, 1'b1, 0);

    // 128 bytes without i_last: truncation, ovf, no pad.
    p = {};
    for (int i = 0; i < DEPTH; i++) p.push_back(8'($urandom));
    send_packet(1, p, 1'b0, 0);

    // Final byte lands exactly on the last word: no pad, no ovf.
    p = {};
    for (int i = 0; i < DEPTH - 1; i++) p.push_back(8'($urandom));
    send_packet(0, p, 1'b1, 0);

    // i_valid gaps of 1..5 cycles.
    p = {};
    for (int i = 0; i < 10; i++) p.push_back(8'($urandom));
    send_packet(0, p, 1'b1, 5);

    // Reset in the middle of PAD, then a fresh packet from address 0.
    reset_during_pad();
    p = {};
    p.push_back(8'hFF);
    p.push_back(8'h80);
    send_packet(1, p, 1'b1, 0);

    // Random packets on random instances.
    for (int k = 0; k < 6; k++) begin
      int inst = int'($urandom_range(0, 1));
      int len  = int'($urandom_range(1, 40));
      p = {};
      for (int i = 0; i < len; i++) p.push_back(8'($urandom));
      send_packet(inst, p, 1'b1, int'($urandom_range(0, 1)) * 3);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty_at_end", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/phy_framer.md
PHY_FRAMER -- requirements
Module: phy_framer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk samples on rising edge, rst clears state immediately and independently of clk.
REQ-002 Parameter DEPTH, default 128, SHALL set the number of 12-bit frame-memory words and the frame count of one transmission.
REQ-003 Parameter SYNC_EN, default 1, SHALL prepend a SYNCH frame (data 0x55) at word 0 when set.
REQ-004 Parameter ADDR_W, default 7, SHALL equal clog2(DEPTH).
REQ-005 Ports, as name, direction, width and meaning:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_valid  in  1  byte offered
- i_byte  in  8  payload byte
- i_last  in  1  final byte of packet, qualified by i_valid
- o_ready  out  1  byte accepted when i_valid&&o_ready
- csb0  out  1  memory chip select, active-low
- web0  out  1  memory write enable, active-low
- addr0  out  ADDR_W  memory word address
- o_data  out  12  frame word to memory
- ten  out  1  transmit enable to loader, active-low
- tend  in  1  loader busy, high while transmitting
- o_done  out  1  one-cycle pulse when transmission completes
- o_ovf  out  1  one-cycle pulse when packet truncated

Function
REQ-006 Frame word format SHALL be: bit0=0 (start), bits8:1=data LSB-first, bit9=even parity (XOR of data bits), bits11:10=2'b11 (stops).
REQ-007 The pad word SHALL be 12'hFFF, which holds the line idle.
REQ-008 States SHALL be IDLE, SYNC, DATA, PAD, START_TX, WAIT_TX.
REQ-009 IDLE:
- o_ready=0, ten=1, csb0=1.
- When i_valid=1, go to SYNC if SYNC_EN=1, else to DATA.
- addr0 SHALL be 0 on exit from IDLE.
REQ-010 SYNC SHALL write 12'hCAA at addr0=0 for one cycle, then enter DATA with addr0=1.
REQ-011 DATA SHALL drive o_ready=1, and each i_valid&&o_ready handshake SHALL register exactly one write in the same edge, visible the following cycle:
- csb0=0, web0=0;
- o_data=frame(i_byte);
- addr0=current word pointer.
REQ-012 The word pointer SHALL increment by one per written word and SHALL NOT wrap within a packet.
REQ-013 A write strobe SHALL last exactly one cycle, with csb0=1 and web0=1 at all other times.
REQ-014 On handshake with i_last=1 and pointer<DEPTH-1, the block SHALL go to PAD.
REQ-015 On handshake with i_last=1 and pointer=DEPTH-1, the block SHALL go to START_TX.
REQ-016 On handshake at pointer=DEPTH-1 with i_last=0:
- the word SHALL be written;
- o_ovf SHALL pulse;
- the block SHALL go to START_TX;
- further bytes SHALL be refused (o_ready=0) until IDLE.
REQ-017 PAD SHALL write 12'hFFF to each remaining address, one per cycle, through DEPTH-1 inclusive, then go to START_TX.
REQ-018 START_TX SHALL drive ten=0 and remain until tend=1, then go to WAIT_TX.
REQ-019 WAIT_TX SHALL hold ten=0 until tend=0. Then it SHALL:
- drive ten=1 the next cycle;
- pulse o_done for one cycle;
- return to IDLE.
REQ-020 o_ready SHALL be 0 in every state except DATA.
REQ-021 Input bytes SHALL be sampled only on handshake, and i_byte/i_last SHALL be ignored otherwise.
REQ-022 If i_valid drops in DATA, the block SHALL wait without timeout and without writing.
REQ-023 Every DEPTH-word memory image SHALL be fully written (payload plus pad) before ten falls.

Reset
REQ-024 On rst=1, regardless of clk, outputs SHALL take these values:
- state=IDLE;
- csb0=1, web0=1;
- addr0=0, o_data=12'hFFF;
- ten=1, o_ready=0;
- o_done=0, o_ovf=0.
REQ-025 Reset mid-packet or mid-transmission SHALL abandon the packet, release ten within the reset, and perform no further memory writes.
REQ-026 After rst deasserts, the first state transition SHALL occur no earlier than the first rising clk edge.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- SYNC_EN=1, single byte 0x01 with i_last: SHALL write 0xCAA@0, then 0xE02@1, then 0xFFF@2..127, then ten=0.
- SYNC_EN=0, bytes 0xA5,0x00(last): SHALL write 0xD4A@0, then 0xC00@1; pad SHALL start at 2.
- 128 bytes with no i_last (SYNC_EN=0): SHALL write byte 127 at addr 127; o_ovf SHALL pulse once; o_ready SHALL be 0 afterwards; there SHALL be no PAD writes.
- Loader model raises tend 3 cycles after ten=0 and drops it 50 cycles later: ten SHALL return to 1, then o_done SHALL pulse once, then the block SHALL return to IDLE.
- i_valid gaps of 1–5 cycles in DATA: there SHALL be no spurious strobes and addresses SHALL be contiguous.
- rst asserted during PAD at addr 60: csb0 SHALL be 1 immediately, ten SHALL be 1, and the next packet SHALL start at addr 0.
